// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding,
// and drives the IF/ID register backed by a single-entry stall hold buffer.
module if_fetch_unit #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    input  logic            halt,
    input  logic            wake,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HALT
    } state_e;

    localparam logic [XLEN-1:0] PC_INC    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_RST    = RESET_PC & ALIGN_MSK;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic            discard_q, discard_d;
    logic            halt_pend_q, halt_pend_d;
    logic            hold_vld_q, hold_vld_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] hold_instr_q, hold_instr_d;
    logic            vld_q, vld_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] instr_q, instr_d;

    logic            granted;
    logic            halt_eff;
    logic            word;
    logic [XLEN-1:0] target;

    assign granted  = (state_q == S_REQ) && req_q && imem_gnt;
    assign halt_eff = halt && !wake;
    assign word     = (state_q == S_WAIT) && imem_rvalid && !discard_q;
    assign target   = branch_target & ALIGN_MSK;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        discard_d    = discard_q;
        halt_pend_d  = halt_pend_q;
        hold_vld_d   = hold_vld_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        vld_d        = vld_q;
        if_pc_d      = if_pc_q;
        instr_d      = instr_q;

        unique case (state_q)
            S_REQ: begin
                if (granted) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + PC_INC;
                    state_d    = S_WAIT;
                    if (halt_eff) begin
                        halt_pend_d = 1'b1;
                    end
                end else if (halt_eff) begin
                    state_d = S_HALT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    discard_d   = 1'b0;
                    halt_pend_d = 1'b0;
                    if (halt_pend_q || halt_eff) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_REQ;
                    end
                end else if (halt_eff) begin
                    halt_pend_d = 1'b1;
                end
            end
            S_HALT: begin
                if (wake) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        // A redirect overrides halt; anything already granted is dropped on return.
        if (flush) begin
            pc_d        = target;
            halt_pend_d = 1'b0;
            hold_vld_d  = 1'b0;
            if (state_q == S_WAIT && !imem_rvalid) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else if (granted) begin
                state_d   = S_WAIT;
                discard_d = 1'b1;
            end else begin
                state_d = S_REQ;
            end
        end

        if (flush) begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
        end else if (stall) begin
            if (word) begin
                hold_vld_d   = 1'b1;
                hold_pc_d    = fetch_pc_q;
                hold_instr_d = imem_rdata;
            end
        end else if (hold_vld_q) begin
            vld_d      = 1'b1;
            if_pc_d    = hold_pc_q;
            instr_d    = hold_instr_q;
            hold_vld_d = 1'b0;
        end else if (word) begin
            vld_d   = 1'b1;
            if_pc_d = fetch_pc_q;
            instr_d = imem_rdata;
        end else begin
            vld_d   = 1'b0;
            instr_d = NOP_INSTR;
        end

        // No new request while a buffered word still waits for decode.
        req_d = (state_d == S_REQ) && !hold_vld_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_REQ;
            pc_q         <= PC_RST;
            fetch_pc_q   <= '0;
            req_q        <= 1'b0;
            discard_q    <= 1'b0;
            halt_pend_q  <= 1'b0;
            hold_vld_q   <= 1'b0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            vld_q        <= 1'b0;
            if_pc_q      <= '0;
            instr_q      <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            req_q        <= req_d;
            discard_q    <= discard_d;
            halt_pend_q  <= halt_pend_d;
            hold_vld_q   <= hold_vld_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            vld_q        <= vld_d;
            if_pc_q      <= if_pc_d;
            instr_q      <= instr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign if_valid  = vld_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = instr_q;

endmodule
